// File: rtl/rot_block_iterative.sv
// Iterative CORDIC rotation block: collects N_ITER direction bits from the vectoring chain,
// then applies one micro-rotation per cycle. Optional gain compensation: ROT_SCALE_COMP_EN.
module rot_block_iterative #(
  parameter int CORDIC_WIDTH = 22,
  parameter int N_ITER       = 16
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           in_valid,
  input  logic signed [CORDIC_WIDTH-1:0] x_in,
  input  logic signed [CORDIC_WIDTH-1:0] y_in,
  input  logic                           micro_rot_valid,
  input  logic                           micro_rot_in,
  input  logic                           micro_rot_start,
  output logic signed [CORDIC_WIDTH-1:0] x_out,
  output logic signed [CORDIC_WIDTH-1:0] y_out,
  output logic                           out_valid,
  output logic                           busy
);

  localparam int CW = $clog2(N_ITER + 1);
  localparam int IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ROTATE  = 2'd2
`ifdef ROT_SCALE_COMP_EN
    , SCALE = 2'd3
`endif
  } state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [IW-1:0]                  iter_q, iter_d;
  logic signed [CORDIC_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [N_ITER-1:0]              bits_q, bits_d;
  logic signed [CORDIC_WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
  logic                           out_valid_q, out_valid_d;
  logic                           busy_q, busy_d;

  logic                           dir;
  logic signed [CORDIC_WIDTH-1:0] x_sh, y_sh, x_rot, y_rot;

`ifdef ROT_SCALE_COMP_EN
  // 1/1.647 approximated as 1/2 + 1/8 - 1/64 - 1/512
  function automatic logic signed [CORDIC_WIDTH-1:0] gain_comp(
    input logic signed [CORDIC_WIDTH-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    iter_d      = iter_q;
    x_d         = x_q;
    y_d         = y_q;
    bits_d      = bits_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    out_valid_d = 1'b0;

    dir = 1'b0;
    for (int k = 0; k < N_ITER; k++)
      if (iter_q == IW'(k)) dir = bits_q[k];
    x_sh  = x_q >>> iter_q;
    y_sh  = y_q >>> iter_q;
    x_rot = dir ? (x_q - y_sh) : (x_q + y_sh);
    y_rot = dir ? (y_q + x_sh) : (y_q - x_sh);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (micro_rot_valid) begin
          // a start bit always restarts the sequence at stage 0
          if (micro_rot_start) begin
            bits_d[0] = micro_rot_in;
            cnt_d     = CW'(1);
          end else begin
            for (int k = 0; k < N_ITER; k++)
              if (cnt_q == CW'(k)) bits_d[k] = micro_rot_in;
            cnt_d = cnt_q + CW'(1);
          end
          if (cnt_d == CW'(N_ITER)) begin
            state_d = ROTATE;
            iter_d  = '0;
          end
        end
      end
      ROTATE: begin
        x_d = x_rot;
        y_d = y_rot;
        if (iter_q == IW'(N_ITER - 1)) begin
`ifdef ROT_SCALE_COMP_EN
          state_d = SCALE;
`else
          x_out_d     = x_rot;
          y_out_d     = y_rot;
          out_valid_d = 1'b1;
          state_d     = IDLE;
`endif
        end else begin
          iter_d = iter_q + IW'(1);
        end
      end
`ifdef ROT_SCALE_COMP_EN
      SCALE: begin
        x_d         = gain_comp(x_q);
        y_d         = gain_comp(y_q);
        x_out_d     = gain_comp(x_q);
        y_out_d     = gain_comp(y_q);
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      iter_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      bits_q      <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      iter_q      <= iter_d;
      x_q         <= x_d;
      y_q         <= y_d;
      bits_q      <= bits_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rot_block_iterative.sv
// Scoreboard bench: a 16-stage instance checked against a bit-true model and a 1-stage
// instance checked against hand-computed vectors; builds with or without ROT_SCALE_COMP_EN.
module tb_rot_block_iterative;
  localparam int W = 22;
  localparam int N = 16;
`ifdef ROT_SCALE_COMP_EN
  localparam int LAT  = N + 1;
  localparam int LAT1 = 2;
`else
  localparam int LAT  = N;
  localparam int LAT1 = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nreset;

  logic iv, mv, mb, ms, ov, bz;
  logic signed [W-1:0] xi, yi, xo, yo;
  logic iv1, mv1, mb1, ms1, ov1, bz1;
  logic signed [W-1:0] xi1, yi1, xo1, yo1;

  rot_block_iterative #(.CORDIC_WIDTH(W), .N_ITER(N)) u_dut (
    .clk(clk), .nreset(nreset), .in_valid(iv), .x_in(xi), .y_in(yi),
    .micro_rot_valid(mv), .micro_rot_in(mb), .micro_rot_start(ms),
    .x_out(xo), .y_out(yo), .out_valid(ov), .busy(bz));

  rot_block_iterative #(.CORDIC_WIDTH(W), .N_ITER(1)) u_dut1 (
    .clk(clk), .nreset(nreset), .in_valid(iv1), .x_in(xi1), .y_in(yi1),
    .micro_rot_valid(mv1), .micro_rot_in(mb1), .micro_rot_start(ms1),
    .x_out(xo1), .y_out(yo1), .out_valid(ov1), .busy(bz1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic signed [W-1:0] x, y; int due; } exp_t;
  typedef struct { int id; int sel; logic signed [W-1:0] x, y; logic b; } probe_t;
  exp_t   q16[$], q1[$];
  probe_t pq[$];
  int n_vec = 0, n_err = 0;
  bit done = 1'b0;

  function automatic logic signed [W-1:0] scale(input logic signed [W-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
  endfunction

  function automatic logic [2*W-1:0] model(input logic signed [W-1:0] x0, y0,
                                           input logic [31:0] bits, input int n);
    logic signed [W-1:0] x, y, xn, yn;
    x = x0; y = y0;
    for (int i = 0; i < n; i++) begin
      if (!bits[i]) begin xn = x + (y >>> i); yn = y - (x >>> i); end
      else          begin xn = x - (y >>> i); yn = y + (x >>> i); end
      x = xn; y = yn;
    end
`ifdef ROT_SCALE_COMP_EN
    x = scale(x); y = scale(y);
`endif
    return {x, y};
  endfunction

  // monitor: sole owner of the counters
  always @(negedge clk) begin
    exp_t e;
    probe_t p;
    logic signed [W-1:0] ax, ay;
    logic ab;
    if (ov) begin
      n_vec++;
      if (q16.size() == 0) begin
        n_err++; $display("FAIL unexpected_ov16 cyc=%0d got x=%0d y=%0d", cyc, xo, yo);
      end else begin
        e = q16.pop_front();
        if (xo !== e.x || yo !== e.y || cyc != e.due) begin
          n_err++;
          $display("FAIL result16 got x=%0d y=%0d cyc=%0d want x=%0d y=%0d cyc=%0d",
                   xo, yo, cyc, e.x, e.y, e.due);
        end
      end
    end
    if (ov1) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_err++; $display("FAIL unexpected_ov1 cyc=%0d got x=%0d y=%0d", cyc, xo1, yo1);
      end else begin
        e = q1.pop_front();
        if (xo1 !== e.x || yo1 !== e.y || cyc != e.due) begin
          n_err++;
          $display("FAIL result1 got x=%0d y=%0d cyc=%0d want x=%0d y=%0d cyc=%0d",
                   xo1, yo1, cyc, e.x, e.y, e.due);
        end
      end
    end
    while (pq.size() > 0) begin
      p = pq.pop_front();
      if (p.sel == 0) begin ax = xo;  ay = yo;  ab = bz;  end
      else            begin ax = xo1; ay = yo1; ab = bz1; end
      n_vec++;
      if (ax !== p.x || ay !== p.y || ab !== p.b) begin
        n_err++;
        $display("FAIL probe%0d_dut%0d got x=%0d y=%0d busy=%0b want x=%0d y=%0d busy=%0b",
                 p.id, p.sel, ax, ay, ab, p.x, p.y, p.b);
      end
    end
    if (done) begin
      n_vec++;
      if (q16.size() != 0 || q1.size() != 0) begin
        n_err++; $display("FAIL drain pending16=%0d pending1=%0d want 0", q16.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic probe(input int id, input int sel, input logic signed [W-1:0] x, y,
                       input logic b);
    probe_t p;
    p.id = id; p.sel = sel; p.x = x; p.y = y; p.b = b;
    pq.push_back(p);
  endtask

  task automatic wait_idle16();
    for (int k = 0; k < 100 && bz; k++) tick();
  endtask

  task automatic start16(input logic signed [W-1:0] x, y);
    wait_idle16();
    iv = 1'b1; xi = x; yi = y; tick(); iv = 1'b0;
  endtask

  task automatic bit16(input logic b, input logic st);
    mv = 1'b1; mb = b; ms = st; tick(); mv = 1'b0; ms = 1'b0;
  endtask

  task automatic expect16(input logic signed [W-1:0] x, y, input logic [31:0] bits);
    exp_t e;
    logic [2*W-1:0] r;
    r = model(x, y, bits, N);
    e.x = r[2*W-1:W]; e.y = r[W-1:0]; e.due = cyc + LAT;
    q16.push_back(e);
  endtask

  task automatic run16(input logic signed [W-1:0] x, y, input logic [31:0] bits);
    start16(x, y);
    for (int i = 0; i < N; i++) bit16(bits[i], i == 0);
    expect16(x, y, bits);
  endtask

  task automatic hand1(input logic signed [W-1:0] x, y, input logic b,
                       input logic signed [W-1:0] ex, ey);
    exp_t e;
    for (int k = 0; k < 20 && bz1; k++) tick();
    iv1 = 1'b1; xi1 = x; yi1 = y; tick(); iv1 = 1'b0;
    mv1 = 1'b1; mb1 = b; ms1 = 1'b1; tick(); mv1 = 1'b0; ms1 = 1'b0;
    e.x = ex; e.y = ey; e.due = cyc + LAT1;
    q1.push_back(e);
  endtask

  function automatic logic signed [W-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return W'($urandom);
      1:       return W'(2097151 - int'($urandom_range(0, 15)));
      2:       return W'(-2097152 + int'($urandom_range(0, 15)));
      default: return W'(int'($urandom_range(0, 2000)) - 1000);
    endcase
  endfunction

  initial begin
    logic [31:0] bits, junk;
    exp_t e;
    nreset = 1'b0;
    iv = 0; mv = 0; mb = 0; ms = 0; xi = '0; yi = '0;
    iv1 = 0; mv1 = 0; mb1 = 0; ms1 = 0; xi1 = '0; yi1 = '0;
    tick(); tick();
    probe(1, 0, 0, 0, 1'b0);
    probe(2, 1, 0, 0, 1'b0);
    tick();
    nreset = 1'b1;
    tick();

    // hand vectors, single-stage instance
`ifdef ROT_SCALE_COMP_EN
    hand1(100, 20, 1'b0, 74, -47);
    hand1(100, 20, 1'b1, 49, 74);
    hand1(-100, 0, 1'b0, -60, 61);
    hand1(2097151, 1, 1'b0, -1273856, -1273855);
    hand1(-2097152, -2097152, 1'b1, 0, 0);
`else
    hand1(100, 20, 1'b0, 120, -80);
    hand1(100, 20, 1'b1, 80, 120);
    hand1(-100, 0, 1'b0, -100, 100);
    hand1(2097151, 1, 1'b0, -2097152, -2097150);
    hand1(-2097152, -2097152, 1'b1, 0, 0);
`endif

    // in_valid held through the result edge is only taken one cycle later
    hand1(100, 20, 1'b0,
`ifdef ROT_SCALE_COMP_EN
          74, -47);
`else
          120, -80);
`endif
    iv1 = 1'b1; xi1 = 10; yi1 = 0;
    for (int k = 0; k < LAT1; k++) tick();
`ifdef ROT_SCALE_COMP_EN
    probe(3, 1, 74, -47, 1'b0);
`else
    probe(3, 1, 120, -80, 1'b0);
`endif
    tick(); iv1 = 1'b0;
`ifdef ROT_SCALE_COMP_EN
    probe(4, 1, 74, -47, 1'b1);
`else
    probe(4, 1, 120, -80, 1'b1);
`endif
    mv1 = 1'b1; mb1 = 1'b0; ms1 = 1'b1; tick(); mv1 = 1'b0; ms1 = 1'b0;
`ifdef ROT_SCALE_COMP_EN
    e.x = 6;  e.y = -5;
`else
    e.x = 10; e.y = -10;
`endif
    e.due = cyc + LAT1;
    q1.push_back(e);
    for (int k = 0; k < 5; k++) tick();

    // restart: 5 stale bits, then a fresh start with 16 bits
    start16(300000, -123456);
    for (int i = 0; i < 5; i++) bit16(1'b1, i == 0);
    bits = 32'h0000_A5C3;
    for (int i = 0; i < N; i++) bit16(bits[i], i == 0);
    expect16(300000, -123456, bits);

    // in_valid and direction bits during ROTATE are ignored
    bits = 32'h0000_3C96;
    run16(-654321, 987654, bits);
    tick(); tick(); tick();
    iv = 1'b1; xi = 5; yi = 5;
    junk = 32'h0000_002D;
    for (int k = 0; k < 6; k++) begin
      mv = 1'b1; mb = junk[k]; ms = (k == 2); tick(); iv = 1'b0;
    end
    mv = 1'b0; ms = 1'b0;
    wait_idle16();
    tick(); tick();

    // reset mid-ROTATE abandons the operation
    start16(1000, 2000);
    for (int i = 0; i < N; i++) bit16(1'b0, i == 0);
    tick(); tick(); tick(); tick();
    nreset = 1'b0;
    probe(5, 0, 0, 0, 1'b0);
    tick(); tick();
    nreset = 1'b1;
    for (int k = 0; k < LAT + 4; k++) tick();
    probe(6, 0, 0, 0, 1'b0);
    run16(1000, 2000, 32'h0000_0000);
    run16(0, 0, 32'h0000_FFFF);

    // random operands, biased toward the wrap-around corners
    for (int r = 0; r < 1000; r++) begin
      logic signed [W-1:0] x, y;
      x = rnd_val(); y = rnd_val(); bits = $urandom;
      run16(x, y, bits);
    end

    wait_idle16();
    for (int k = 0; k < LAT + 4 && (q16.size() != 0 || q1.size() != 0); k++) tick();
    tick();
    done = 1'b1;
  end

endmodule
